// File: rtl/slip_pkg.sv
// SLIP (RFC 1055) framing codes and decoder state encoding shared by the
// axis_slip_rx decoder.
package slip_pkg;

  localparam logic [7:0] SLIP_END     = 8'hC0;
  localparam logic [7:0] SLIP_ESC     = 8'hDB;
  localparam logic [7:0] SLIP_ESC_END = 8'hDC;
  localparam logic [7:0] SLIP_ESC_ESC = 8'hDD;

  typedef enum logic {
    ST_NORMAL  = 1'b0,
    ST_ESCAPED = 1'b1
  } slip_state_e;

endpackage

// File: rtl/axis_slip_rx_if.sv
// AXI-Stream bundle used on both sides of the SLIP decoder.
// Handshake: a beat transfers on a clock edge where tvalid && tready; the
// master holds tdata/tlast/tuser stable while tvalid && !tready.
interface axis_slip_rx_if #(
  parameter int DW = 8
) ();
  logic [DW-1:0] tdata;
  logic          tuser;
  logic          tlast;
  logic          tvalid;
  logic          tready;

  modport master (output tdata, output tuser, output tlast, output tvalid, input tready);
  modport slave  (input tdata, input tuser, input tlast, input tvalid, output tready);
endinterface

// File: rtl/axis_slip_rx.sv
// SLIP frame decoder: UART characters in, packet-framed bytes out.
// Define SLIP_RX_STATS_EN to build the good/bad frame counters.
module axis_slip_rx
  import slip_pkg::*;
#(
  parameter int MAX_LEN = 1500,
  parameter int LEN_W   = 16
) (
  input  logic                  aclk,
  input  logic                  areset,
  axis_slip_rx_if.slave         s_axis,
  axis_slip_rx_if.master        m_axis,
  output logic [15:0]           stat_frames,
  output logic [15:0]           stat_errors
);

  slip_state_e      st_q, st_d;
  logic [7:0]       hold_q, hold_d;
  logic             hold_vld_q, hold_vld_d;
  logic             err_q, err_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [7:0]       m_data_q, m_data_d;
  logic             m_last_q, m_last_d;
  logic             m_user_q, m_user_d;
  logic             m_valid_q, m_valid_d;

  logic       take;
  logic [7:0] ch;
  logic [7:0] dbyte;
  logic       err_n;
  logic       is_end;
  logic       have_byte;
  logic       inc_frame;
  logic       inc_error;
  logic       unused_in;

  // Upper character bits and the input tlast carry no meaning for SLIP.
  assign unused_in = ^{s_axis.tdata, s_axis.tlast};

  assign ch             = s_axis.tdata[7:0];
  assign s_axis.tready  = !areset && (!m_valid_q || m_axis.tready);
  assign take           = s_axis.tvalid && s_axis.tready;

  assign m_axis.tdata   = m_data_q;
  assign m_axis.tlast   = m_last_q;
  assign m_axis.tuser   = m_user_q;
  assign m_axis.tvalid  = m_valid_q;

  always_comb begin
    st_d       = st_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    m_data_d   = m_data_q;
    m_last_d   = m_last_q;
    m_user_d   = m_user_q;
    m_valid_d  = m_valid_q && !m_axis.tready;
    inc_frame  = 1'b0;
    inc_error  = 1'b0;
    err_n      = err_q | s_axis.tuser;
    is_end     = 1'b0;
    have_byte  = 1'b0;
    dbyte      = ch;

    if (take) begin
      unique case (st_q)
        ST_NORMAL: begin
          if (ch == SLIP_END)      is_end = 1'b1;
          else if (ch == SLIP_ESC) st_d = ST_ESCAPED;
          else                     have_byte = 1'b1;
        end
        ST_ESCAPED: begin
          st_d = ST_NORMAL;
          if (ch == SLIP_ESC_END) begin
            have_byte = 1'b1;
            dbyte     = SLIP_END;
          end else if (ch == SLIP_ESC_ESC) begin
            have_byte = 1'b1;
            dbyte     = SLIP_ESC;
          end else if (ch == SLIP_END) begin
            err_n  = 1'b1;
            is_end = 1'b1;
          end else begin
            err_n = 1'b1;
          end
        end
        default: st_d = ST_NORMAL;
      endcase

      if (is_end) begin
        // An empty hold register means there is no byte to carry tlast.
        if (hold_vld_q) begin
          m_valid_d = 1'b1;
          m_data_d  = hold_q;
          m_last_d  = 1'b1;
          m_user_d  = err_n;
          inc_frame = !err_n;
          inc_error = err_n;
        end else if (err_n) begin
          inc_error = 1'b1;
        end
        err_d      = 1'b0;
        cnt_d      = '0;
        hold_vld_d = 1'b0;
        st_d       = ST_NORMAL;
      end else begin
        err_d = err_n;
        if (have_byte) begin
          if (cnt_q == LEN_W'(MAX_LEN)) begin
            err_d = 1'b1;
          end else begin
            cnt_d = cnt_q + LEN_W'(1);
            if (hold_vld_q) begin
              m_valid_d = 1'b1;
              m_data_d  = hold_q;
              m_last_d  = 1'b0;
              m_user_d  = 1'b0;
            end
            hold_d     = dbyte;
            hold_vld_d = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      st_q       <= ST_NORMAL;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
      m_data_q   <= '0;
      m_last_q   <= 1'b0;
      m_user_q   <= 1'b0;
      m_valid_q  <= 1'b0;
    end else begin
      st_q       <= st_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      m_data_q   <= m_data_d;
      m_last_q   <= m_last_d;
      m_user_q   <= m_user_d;
      m_valid_q  <= m_valid_d;
    end
  end

`ifdef SLIP_RX_STATS_EN
  logic [15:0] frames_q;
  logic [15:0] errors_q;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      frames_q <= '0;
      errors_q <= '0;
    end else begin
      if (inc_frame) frames_q <= frames_q + 16'd1;
      if (inc_error) errors_q <= errors_q + 16'd1;
    end
  end

  assign stat_frames = frames_q;
  assign stat_errors = errors_q;
`else
  logic unused_stats;
  assign unused_stats = inc_frame | inc_error;
  assign stat_frames  = '0;
  assign stat_errors  = '0;
`endif

endmodule

// File: tb/tb_axis_slip_rx.sv
// Directed bench for axis_slip_rx: per-character vector table plus
// backpressure and mid-frame reset sequences.
module tb_axis_slip_rx;

  localparam int MAX_LEN = 8;
`ifdef SLIP_RX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        aclk   = 1'b0;
  logic        areset = 1'b1;
  logic [15:0] stat_frames;
  logic [15:0] stat_errors;

  axis_slip_rx_if #(.DW(16)) s_if ();
  axis_slip_rx_if #(.DW(8))  m_if ();

  axis_slip_rx #(.MAX_LEN(MAX_LEN), .LEN_W(16)) dut (
    .aclk        (aclk),
    .areset      (areset),
    .s_axis      (s_if),
    .m_axis      (m_if),
    .stat_frames (stat_frames),
    .stat_errors (stat_errors)
  );

  // ---------------- clock / reset ----------------
  always #5 aclk = ~aclk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  int exp_frames = 0;
  int exp_errors = 0;
  logic [9:0] exp_q[$];

  typedef struct {
    logic [7:0] ch;
    logic       par;
    logic       emit;
    logic [7:0] d;
    logic       last;
    logic       user;
    logic       drop;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [7:0] ch, logic par, logic emit, logic [7:0] d,
                              logic last, logic user, logic drop);
    vec_t v;
    v.ch = ch; v.par = par; v.emit = emit; v.d = d;
    v.last = last; v.user = user; v.drop = drop;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_stats(string tag);
    check({tag, "_stat_frames"}, 32'(stat_frames), STATS ? 32'(exp_frames[15:0]) : 32'd0);
    check({tag, "_stat_errors"}, 32'(stat_errors), STATS ? 32'(exp_errors[15:0]) : 32'd0);
  endtask

  task automatic check_reset_state();
    check("rst_m_tvalid", 32'(m_if.tvalid), 32'd0);
    check("rst_m_tdata",  32'(m_if.tdata),  32'd0);
    check("rst_m_tlast",  32'(m_if.tlast),  32'd0);
    check("rst_m_tuser",  32'(m_if.tuser),  32'd0);
    check("rst_s_tready", 32'(s_if.tready), 32'd0);
    check("rst_stat_frames", 32'(stat_frames), 32'd0);
    check("rst_stat_errors", 32'(stat_errors), 32'd0);
  endtask

  // ---------------- driver tasks ----------------
  // One character per cycle with m_tready held high; the beat caused by the
  // character is visible right after the edge that consumed it.
  task automatic run_vec(vec_t v, int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    @(negedge aclk);
    s_if.tdata  = {8'($urandom_range(0, 255)), v.ch};
    s_if.tuser  = v.par;
    s_if.tvalid = 1'b1;
    #1;
    check({tag, "_s_tready"}, 32'(s_if.tready), 32'd1);
    @(posedge aclk);
    #1;
    s_if.tvalid = 1'b0;
    s_if.tuser  = 1'b0;
    check({tag, "_m_tvalid"}, 32'(m_if.tvalid), 32'(v.emit));
    if (v.emit) begin
      check({tag, "_m_tdata"}, 32'(m_if.tdata), 32'(v.d));
      check({tag, "_m_tlast"}, 32'(m_if.tlast), 32'(v.last));
      check({tag, "_m_tuser"}, 32'(m_if.tuser), 32'(v.user));
      if (v.last) begin
        if (v.user) exp_errors++;
        else        exp_frames++;
      end
    end
    if (v.drop) exp_errors++;
    check_stats(tag);
  endtask

  task automatic run_backpressure();
    logic [7:0] chars[9];
    logic       stall_prev;
    logic [10:0] held;
    logic       will_take;
    int         idx;
    int         cyc;
    for (int i = 0; i < 8; i++) begin
      chars[i] = 8'(i + 1);
      exp_q.push_back({8'(i + 1), (i == 7), 1'b0});
    end
    chars[8]   = 8'hC0;
    idx        = 0;
    cyc        = 0;
    stall_prev = 1'b0;
    held       = '0;
    while ((idx < 9 || exp_q.size() > 0) && cyc < 200) begin
      @(negedge aclk);
      m_if.tready = (cyc % 2 == 0);
      if (idx < 9) begin
        s_if.tdata  = {8'($urandom_range(0, 255)), chars[idx]};
        s_if.tvalid = 1'b1;
      end else begin
        s_if.tvalid = 1'b0;
      end
      #1;
      if (stall_prev)
        check("bp_stall_stable", 32'({m_if.tvalid, m_if.tdata, m_if.tlast, m_if.tuser}), 32'(held));
      will_take = s_if.tvalid && s_if.tready;
      if (m_if.tvalid && m_if.tready) begin
        if (exp_q.size() == 0) begin
          check("bp_extra_beat", 32'({m_if.tdata, m_if.tlast, m_if.tuser}), 32'h3ff);
        end else begin
          check("bp_beat", 32'({m_if.tdata, m_if.tlast, m_if.tuser}), 32'(exp_q.pop_front()));
        end
      end
      stall_prev = m_if.tvalid && !m_if.tready;
      held       = {m_if.tvalid, m_if.tdata, m_if.tlast, m_if.tuser};
      @(posedge aclk);
      if (will_take) idx++;
      cyc++;
    end
    check("bp_chars_consumed", 32'(idx), 32'd9);
    check("bp_beats_pending", 32'(exp_q.size()), 32'd0);
    @(negedge aclk);
    s_if.tvalid = 1'b0;
    m_if.tready = 1'b1;
    exp_frames++;
    #1;
    check_stats("bp");
  endtask

  // ---------------- test sequence ----------------
  initial begin
    s_if.tdata  = '0;
    s_if.tuser  = 1'b0;
    s_if.tlast  = 1'b0;
    s_if.tvalid = 1'b0;
    m_if.tready = 1'b1;

    // Basic frame
    vecs.push_back(mk(8'hC0, 0, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mk(8'h01, 0, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mk(8'h02, 0, 1, 8'h01, 0, 0, 0));
    vecs.push_back(mk(8'h03, 0, 1, 8'h02, 0, 0, 0));
    vecs.push_back(mk(8'hC0, 0, 1, 8'h03, 1, 0, 0));
    // Escapes
    vecs.push_back(mk(8'h41, 0, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mk(8'hDB, 0, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mk(8'hDC, 0, 1, 8'h41, 0, 0, 0));
    vecs.push_back(mk(8'hDB, 0, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mk(8'hDD, 0, 1, 8'hC0, 0, 0, 0));
    vecs.push_back(mk(8'h42, 0, 1, 8'hDB, 0, 0, 0));
    vecs.push_back(mk(8'hC0, 0, 1, 8'h42, 1, 0, 0));
    // Back-to-back END
    vecs.push_back(mk(8'hC0, 0, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mk(8'hC0, 0, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mk(8'hC0, 0, 0, 8'h00, 0, 0, 0));
    // Bad escape
    vecs.push_back(mk(8'h05, 0, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mk(8'hDB, 0, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mk(8'h07, 0, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mk(8'h06, 0, 1, 8'h05, 0, 0, 0));
    vecs.push_back(mk(8'hC0, 0, 1, 8'h06, 1, 1, 0));
    // Parity error on a payload byte
    vecs.push_back(mk(8'h10, 1, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mk(8'h11, 0, 1, 8'h10, 0, 0, 0));
    vecs.push_back(mk(8'hC0, 0, 1, 8'h11, 1, 1, 0));
    // Parity error on a lone END: dropped error frame
    vecs.push_back(mk(8'hC0, 1, 0, 8'h00, 0, 0, 1));
    // Parity error on the closing END
    vecs.push_back(mk(8'h20, 0, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mk(8'hC0, 1, 1, 8'h20, 1, 1, 0));
    // Overlength: 10 bytes against MAX_LEN=8
    vecs.push_back(mk(8'h01, 0, 0, 8'h00, 0, 0, 0));
    for (int i = 2; i <= 8; i++)
      vecs.push_back(mk(8'(i), 0, 1, 8'(i - 1), 0, 0, 0));
    vecs.push_back(mk(8'h09, 0, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mk(8'h0A, 0, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mk(8'hC0, 0, 1, 8'h08, 1, 1, 0));
    // ESC followed by END closes the frame flagged
    vecs.push_back(mk(8'h33, 0, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mk(8'hDB, 0, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mk(8'hC0, 0, 1, 8'h33, 1, 1, 0));
    // ESC END with nothing held: dropped error frame
    vecs.push_back(mk(8'hDB, 0, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mk(8'hC0, 0, 0, 8'h00, 0, 0, 1));

    repeat (2) @(negedge aclk);
    #1;
    check_reset_state();
    @(negedge aclk);
    areset = 1'b0;

    for (int i = 0; i < vecs.size(); i++)
      run_vec(vecs[i], i);

    run_backpressure();

    // Reset in the middle of an escaped, errored frame
    run_vec(mk(8'h55, 1, 0, 8'h00, 0, 0, 0), 100);
    run_vec(mk(8'hDB, 0, 0, 8'h00, 0, 0, 0), 101);
    @(negedge aclk);
    areset = 1'b1;
    #1;
    check_reset_state();
    exp_frames = 0;
    exp_errors = 0;
    @(negedge aclk);
    areset = 1'b0;
    run_vec(mk(8'h0A, 0, 0, 8'h00, 0, 0, 0), 102);
    run_vec(mk(8'hC0, 0, 1, 8'h0A, 1, 0, 0), 103);

    repeat (2) @(negedge aclk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
